audio_adc_receiver: RTL and testbench
=====================================

Name: audio_adc_receiver

Overview:
- Capture side of the WM8731 audio interface: deserializes AUD_ADCDAT into parallel left/right samples using the codec-facing AUD_BCLK and AUD_ADCLRCK.
- Format is left-justified, MSB first, DATA_WIDTH bits per channel.
- Runs entirely in the CLOCK_27 domain; AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT are oversampled, not used as clocks.
- Delivers one stereo frame per LRCK period over a valid/ready handshake to downstream logic such as record buffers, loopback and the LED level meter.

Parameters:
- DATA_WIDTH, 16, bits per channel word.
- SYNC_STAGES, 2, flip-flop stages on each pin input (minimum 2).
- LEFT_LRCK_LEVEL, 1, AUD_ADCLRCK level that marks the left channel.

Ports:
- CLOCK_27  in  1  system clock, 27 MHz; all logic is on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- AUD_BCLK  in  1  bit clock from the clock generator, roughly 1.5 MHz, asynchronous sampling.
- AUD_ADCLRCK  in  1  ADC frame clock, 48 kHz.
- AUD_ADCDAT  in  1  serial ADC data.
- enable  in  1  0 = drop frames; the framing tracker still runs.
- out_left  out  DATA_WIDTH  last left sample, two's complement as received.
- out_right  out  DATA_WIDTH  last right sample.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts the frame.
- overrun  out  1  sticky flag: a frame was overwritten before it was accepted.
- frame_err  out  1  sticky flag: a short word was detected.
- clr_status  in  1  one-cycle pulse that clears overrun and frame_err.
- level  out  4  magnitude meter of the left channel.

Behaviour:
- Reset (synchronous, active-high) sets every output to 0, the state to HUNT, the bit counter to 0 and the shift registers to 0. Reset asserted mid-word abandons the word; no partial frame is ever output.
- Synchronizer: each pin passes through SYNC_STAGES flops, then one delay flop.
  - bclk_rise = synchronized BCLK high and delayed BCLK low.
  - Bits and LRCK are sampled only on the bclk_rise cycle, using the synchronized values.
  - BCLK falling edges are ignored.
- lrck_prev holds the LRCK value at the previous bclk_rise. An LRCK change between two rises is a word start.
- State HUNT: ignore data until the first word start where LRCK equals LEFT_LRCK_LEVEL, then go to LEFT. The first bit is captured on that same rise.
- State LEFT: shift the sampled data bit into sh, MSB first, and increment bit_cnt.
  - When bit_cnt reaches DATA_WIDTH, copy sh into left_hold; any further bits in the slot are ignored.
  - A word start to the right channel moves to RIGHT, capturing that bit as the right MSB.
- State RIGHT: same capture into right_hold.
  - A word start back to left completes the frame and moves to LEFT, capturing the new left MSB on the same rise.
- Short word: a word start while bit_cnt < DATA_WIDTH sets frame_err, discards the current frame and returns to HUNT. A new left start on that same rise is accepted immediately.
- Frame completion (only if enable = 1):
  - In the next CLOCK_27 cycle, out_left and out_right load the held values and out_valid becomes 1.
  - Latency from the pin edge is SYNC_STAGES + 2 cycles after the first BCLK rise of the next left word.
- Handshake:
  - out_valid stays high and the data stays stable until a cycle with out_valid and out_ready both high; then out_valid drops next cycle.
  - Completion while out_valid = 1 and out_ready = 0: overwrite the data, keep out_valid = 1, set overrun.
  - Completion in the same cycle as an acceptance: load the new data, out_valid stays 1, no overrun.
- Sticky flags: clr_status clears overrun and frame_err. If a set event and clr_status occur in the same cycle, set wins.
- level, updated on each loaded frame:
  - a = |out_left|, with -2^(DATA_WIDTH-1) saturating to 2^(DATA_WIDTH-1)-1.
  - level = a[DATA_WIDTH-2 : DATA_WIDTH-5].
- bit_cnt saturates at DATA_WIDTH and never wraps.

Decomposition:
- Package audio_codec_pkg holds DATA_WIDTH, REF_CLK = 18432000, SAMPLE_RATE = 48000, CHANNEL_NUM = 2, the derived BCLK divide constant, and an enum for the states HUNT/LEFT/RIGHT. The DAC tone generator uses the same package.
- One sub-module, audio_pin_sync: a parameterized synchronizer with rise/fall strobes, instantiated for BCLK, LRCK and DAT.

Test Plan:
- Drive a BCLK of 1.536 MHz with left = 16'h7FFF, right = 16'h8001, repeated. Expect out_left = 7FFF, out_right = 8001, level = 4'hF, out_valid once per 48 kHz frame, no flags.
- Hold out_ready = 0 across 2 frames with left = 0x1234 then 0x5678. Expect out_left = 0x5678, out_valid = 1, overrun = 1. A clr_status pulse then clears overrun.
- Insert a left word of only 10 BCLKs. Expect frame_err = 1 and that frame never reported. The next full frame, 0x0F0F/0xF0F0, is reported correctly.
- Assert Reset for 1 cycle after 8 right-channel bits. Expect all outputs 0 and HUNT state. The first valid frame arrives only after the next left-start edge.
- Send 20-bit slots carrying 16 MSBs 0xA5A5 and 4 trailing garbage bits. Expect out_left = 0xA5A5 (extra bits ignored).
- Hold enable = 0 for 3 frames, then set 1. Expect no out_valid while disabled; the first frame completed after enable rises is delivered.

Source files
------------

// File: rtl/audio_codec_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : audio_codec_pkg
//  Purpose  : Shared constants and types for the WM8731 audio interface
//             (ADC receiver and DAC tone generator).
//  Contents : DATA_WIDTH, REF_CLK, SAMPLE_RATE, CHANNEL_NUM, BCLK_DIV,
//             adc_state_e (HUNT / LEFT / RIGHT framing states).
//  Revision : 1.0  initial release
// ============================================================================
package audio_codec_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int REF_CLK     = 18432000;
    localparam int SAMPLE_RATE = 48000;
    localparam int CHANNEL_NUM = 2;

    // BCLK toggles twice per bit, so the reference clock is divided down to
    // half a bit period: 18.432 MHz / (48 kHz * 16 * 2 * 2) = 6.
    localparam int BCLK_DIV    = REF_CLK / (SAMPLE_RATE * DATA_WIDTH * CHANNEL_NUM * 2);

    // Framing tracker states.
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } adc_state_e;

endpackage : audio_codec_pkg
`default_nettype wire

// File: rtl/audio_pin_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : audio_pin_sync
//  Purpose  : Multi-flop synchronizer for one asynchronous pin, followed by
//             a delay flop that provides single-cycle rise/fall strobes.
//  Ports    : clk      system clock
//             rst      synchronous active-high reset
//             i_pin    asynchronous pin input
//             o_level  synchronized pin level
//             o_rise   one-cycle strobe, synchronized level went 0 -> 1
//             o_fall   one-cycle strobe, synchronized level went 1 -> 0
//  Notes    : STAGES must be at least 2.
//  Revision : 1.0  initial release
// ============================================================================
module audio_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_dly  <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  =  r_sync[STAGES-1] & ~r_dly;
    assign o_fall  = ~r_sync[STAGES-1] &  r_dly;

endmodule : audio_pin_sync
`default_nettype wire

// File: rtl/audio_adc_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : audio_adc_receiver
//  Purpose  : WM8731 ADC capture path. Oversamples BCLK / ADCLRCK / ADCDAT in
//             the CLOCK_27 domain, deserializes left-justified MSB-first
//             words and hands out one stereo frame per LRCK period over a
//             valid/ready handshake, with sticky error flags and a level meter.
//  Ports    : CLOCK_27     system clock (all logic on rising edge)
//             Reset        synchronous active-high reset
//             AUD_BCLK     codec bit clock (sampled, not used as a clock)
//             AUD_ADCLRCK  codec ADC frame clock (sampled)
//             AUD_ADCDAT   serial ADC data (sampled)
//             enable       0 = completed frames are dropped
//             out_left     last delivered left sample
//             out_right    last delivered right sample
//             out_valid    frame available
//             out_ready    consumer accepts the frame
//             overrun      sticky: unaccepted frame was overwritten
//             frame_err    sticky: short word detected
//             clr_status   pulse clearing overrun and frame_err
//             level        4-bit magnitude of the delivered left sample
//  Revision : 1.0  initial release
// ============================================================================
module audio_adc_receiver #(
    parameter int DATA_WIDTH      = audio_codec_pkg::DATA_WIDTH,
    parameter int SYNC_STAGES     = 2,
    parameter bit LEFT_LRCK_LEVEL = 1'b1
) (
    input  logic                  CLOCK_27,
    input  logic                  Reset,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] out_left,
    output logic [DATA_WIDTH-1:0] out_right,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    output logic                  frame_err,
    input  logic                  clr_status,
    output logic [3:0]            level
);

    import audio_codec_pkg::*;

    localparam int                c_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    // ------------------------------------------------------------------
    // Pin synchronizers
    // ------------------------------------------------------------------
    logic w_bclk_lvl, w_bclk_rise, w_bclk_fall;
    logic w_lrck,     w_lrck_rise, w_lrck_fall;
    logic w_dat,      w_dat_rise,  w_dat_fall;

    audio_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk     (CLOCK_27),
        .rst     (Reset),
        .i_pin   (AUD_BCLK),
        .o_level (w_bclk_lvl),
        .o_rise  (w_bclk_rise),
        .o_fall  (w_bclk_fall)
    );

    audio_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk     (CLOCK_27),
        .rst     (Reset),
        .i_pin   (AUD_ADCLRCK),
        .o_level (w_lrck),
        .o_rise  (w_lrck_rise),
        .o_fall  (w_lrck_fall)
    );

    audio_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_dat (
        .clk     (CLOCK_27),
        .rst     (Reset),
        .i_pin   (AUD_ADCDAT),
        .o_level (w_dat),
        .o_rise  (w_dat_rise),
        .o_fall  (w_dat_fall)
    );

    // ------------------------------------------------------------------
    // Framing tracker
    // ------------------------------------------------------------------
    adc_state_e              r_state, w_state_nxt;
    logic                    r_lrck_prev;
    logic                    r_lrck_seen;
    logic [DATA_WIDTH-1:0]   r_sh,    w_sh_nxt;
    logic [c_CNT_W-1:0]      r_cnt,   w_cnt_nxt;
    logic [DATA_WIDTH-1:0]   r_lhold, w_lhold_nxt;
    logic [DATA_WIDTH-1:0]   r_rhold, w_rhold_nxt;
    logic                    w_done;
    logic                    w_short;

    logic                    w_is_left;
    logic                    w_word_start;
    logic [DATA_WIDTH-1:0]   w_sh_shift;
    logic [DATA_WIDTH-1:0]   w_sh_first;

    assign w_is_left    = (w_lrck == LEFT_LRCK_LEVEL);
    // The first rise after reset only primes r_lrck_prev, so reset in the
    // middle of a left slot cannot fake a word start.
    assign w_word_start = w_bclk_rise & r_lrck_seen & (w_lrck != r_lrck_prev);
    assign w_sh_shift   = {r_sh[DATA_WIDTH-2:0], w_dat};
    assign w_sh_first   = {{(DATA_WIDTH-1){1'b0}}, w_dat};

    always_ff @(posedge CLOCK_27) begin
        if (Reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        w_lhold_nxt = r_lhold;
        w_rhold_nxt = r_rhold;
        w_done      = 1'b0;
        w_short     = 1'b0;

        if (w_bclk_rise) begin
            case (r_state)
                HUNT: begin
                    if (w_word_start && w_is_left) begin
                        w_state_nxt = LEFT;
                        w_sh_nxt    = w_sh_first;
                        w_cnt_nxt   = c_ONE;
                    end
                end

                LEFT, RIGHT: begin
                    if (w_word_start) begin
                        if (r_cnt != c_FULL) begin
                            // Short word: drop the frame. A left start on the
                            // same rise re-synchronizes immediately.
                            w_short = 1'b1;
                            if (w_is_left) begin
                                w_state_nxt = LEFT;
                                w_sh_nxt    = w_sh_first;
                                w_cnt_nxt   = c_ONE;
                            end else begin
                                w_state_nxt = HUNT;
                                w_sh_nxt    = '0;
                                w_cnt_nxt   = '0;
                            end
                        end else begin
                            w_done      = (r_state == RIGHT) && enable;
                            w_state_nxt = w_is_left ? LEFT : RIGHT;
                            w_sh_nxt    = w_sh_first;
                            w_cnt_nxt   = c_ONE;
                        end
                    end else if (r_cnt != c_FULL) begin
                        // Bits past DATA_WIDTH in a slot are ignored because
                        // the counter parks at full.
                        w_sh_nxt  = w_sh_shift;
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
                            if (r_state == LEFT) begin
                                w_lhold_nxt = w_sh_shift;
                            end else begin
                                w_rhold_nxt = w_sh_shift;
                            end
                        end
                    end
                end

                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_27) begin
        if (Reset) begin
            r_lrck_prev <= 1'b0;
            r_lrck_seen <= 1'b0;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_lhold     <= '0;
            r_rhold     <= '0;
        end else begin
            if (w_bclk_rise) begin
                r_lrck_prev <= w_lrck;
                r_lrck_seen <= 1'b1;
            end
            r_sh    <= w_sh_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lhold <= w_lhold_nxt;
            r_rhold <= w_rhold_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Level meter: |left| with the most negative code saturated
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_abs;
    logic [3:0]            w_level_nxt;

    always_comb begin
        if (r_lhold == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
            w_abs = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (r_lhold[DATA_WIDTH-1]) begin
            w_abs = (~r_lhold) + 1'b1;
        end else begin
            w_abs = r_lhold;
        end
        w_level_nxt = w_abs[DATA_WIDTH-2 -: 4];
    end

    // ------------------------------------------------------------------
    // Output stage and handshake
    // ------------------------------------------------------------------
    logic                  r_complete;
    logic [DATA_WIDTH-1:0] r_left;
    logic [DATA_WIDTH-1:0] r_right;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  r_frame_err;
    logic [3:0]            r_level;
    logic                  w_ovr_set;

    // Overwrite only counts as overrun when the pending frame is not being
    // taken in this very cycle.
    assign w_ovr_set = r_complete & r_valid & ~out_ready;

    always_ff @(posedge CLOCK_27) begin
        if (Reset) begin
            r_complete  <= 1'b0;
            r_left      <= '0;
            r_right     <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_level     <= '0;
        end else begin
            r_complete <= w_done;
            if (r_complete) begin
                r_left  <= r_lhold;
                r_right <= r_rhold;
                r_valid <= 1'b1;
                r_level <= w_level_nxt;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            // Set has priority over clear.
            r_overrun   <= w_ovr_set | (r_overrun   & ~clr_status);
            r_frame_err <= w_short   | (r_frame_err & ~clr_status);
        end
    end

    assign out_left  = r_left;
    assign out_right = r_right;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign level     = r_level;

    // Strobes and meter bits this block does not need.
    logic w_unused;
    assign w_unused = ^{w_bclk_lvl, w_bclk_fall, w_lrck_rise, w_lrck_fall,
                        w_dat_rise, w_dat_fall, w_abs};

endmodule : audio_adc_receiver
`default_nettype wire

// File: tb/tb_audio_adc_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_audio_adc_receiver
//  Purpose  : Directed self-checking bench for audio_adc_receiver. Serial
//             frames are generated with a 1.536 MHz BCLK against a 27 MHz
//             system clock; expected samples and levels are hand-computed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_audio_adc_receiver;

    localparam real CLK_HALF = 18.5;   // ~27 MHz
    localparam int  BHALF    = 325;    // ~1.536 MHz BCLK

    logic        clk;
    logic        Reset;
    logic        AUD_BCLK;
    logic        AUD_ADCLRCK;
    logic        AUD_ADCDAT;
    logic        enable;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        frame_err;
    logic        clr_status;
    logic [3:0]  level;

    audio_adc_receiver #(
        .DATA_WIDTH      (16),
        .SYNC_STAGES     (2),
        .LEFT_LRCK_LEVEL (1'b1)
    ) dut (
        .CLOCK_27    (clk),
        .Reset       (Reset),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_ADCLRCK (AUD_ADCLRCK),
        .AUD_ADCDAT  (AUD_ADCDAT),
        .enable      (enable),
        .out_left    (out_left),
        .out_right   (out_right),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .clr_status  (clr_status),
        .level       (level)
    );

    initial clk = 1'b0;
    always #(CLK_HALF) clk = ~clk;

    // ------------------------------------------------------------------
    // Handshake monitor: a transfer is a cycle with valid and ready high.
    // ------------------------------------------------------------------
    int          n_acc   = 0;
    int          n_vrise = 0;
    logic        prev_v  = 1'b0;
    logic [15:0] last_l  = '0;
    logic [15:0] last_r  = '0;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            n_acc  = n_acc + 1;
            last_l = out_left;
            last_r = out_right;
        end
        if (out_valid && !prev_v) n_vrise = n_vrise + 1;
        prev_v = out_valid;
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Serial stimulus: data/LRCK change on BCLK low, codec-style.
    // ------------------------------------------------------------------
    task automatic send_bit(input logic lr, input logic b);
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = lr;
        AUD_ADCDAT  = b;
        #(BHALF);
        AUD_BCLK    = 1'b1;
        #(BHALF);
    endtask

    // nbits up to 20; bits beyond 16 come from tail, MSB first.
    task automatic send_word(input logic lr, input logic [15:0] v, input int nbits, input logic [3:0] tail);
        logic [31:0] w;
        w = {v, tail, 12'h000};
        for (int i = 0; i < nbits; i++) send_bit(lr, w[31-i]);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nbits, input logic [3:0] tail);
        send_word(1'b1, l, nbits, tail);
        send_word(1'b0, r, nbits, tail);
    endtask

    // Control inputs change early in a cycle, so the monitor and the DUT see
    // the same value at the following edge.
    task automatic set_ready(input logic v);
        @(posedge clk); #2;
        out_ready = v;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #2; clr_status = 1'b1;
        @(posedge clk); #2; clr_status = 1'b0;
    endtask

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [3:0]  lvl;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a, a2, vr;

        vecs[0] = '{16'h7FFF, 16'h8001, 4'hF};
        vecs[1] = '{16'h8000, 16'h7FFF, 4'hF};  // most negative saturates
        vecs[2] = '{16'h0000, 16'hFFFF, 4'h0};
        vecs[3] = '{16'hFFFF, 16'h0000, 4'h0};  // -1 -> 1
        vecs[4] = '{16'h0800, 16'hC000, 4'h1};
        vecs[5] = '{16'hC000, 16'h0800, 4'h8};  // -0x4000
        vecs[6] = '{16'h1234, 16'hABCD, 4'h2};
        vecs[7] = '{16'h7FFF, 16'h8001, 4'hF};

        Reset = 1'b1; AUD_BCLK = 1'b0; AUD_ADCLRCK = 1'b0; AUD_ADCDAT = 1'b0;
        enable = 1'b1; out_ready = 1'b1; clr_status = 1'b0;
        repeat (5) @(posedge clk);
        #2 Reset = 1'b0;
        @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_left",  {16'd0, out_left},  32'd0);
        check("reset out_right", {16'd0, out_right}, 32'd0);
        check("reset flags",     {30'd0, overrun, frame_err}, 32'd0);
        check("reset level",     {28'd0, level},     32'd0);

        // Idle in the right-channel level before the first left start.
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);

        // ---- Table: each frame is delivered at the next frame's left start.
        a = n_acc;
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].l, vecs[i].r, 16, 4'h0);
            if (i > 0) begin
                check("tbl count", n_acc - a, i);
                check("tbl left",  {16'd0, last_l},  {16'd0, vecs[i-1].l});
                check("tbl right", {16'd0, last_r},  {16'd0, vecs[i-1].r});
                check("tbl level", {28'd0, level},   {28'd0, vecs[i-1].lvl});
            end
        end
        send_frame(16'h0000, 16'h0000, 16, 4'h0);
        check("tbl last left",  {16'd0, last_l}, {16'd0, vecs[7].l});
        check("tbl last right", {16'd0, last_r}, {16'd0, vecs[7].r});
        check("tbl count end",  n_acc - a, 8);
        check("tbl valid idle", {31'd0, out_valid}, 32'd0);
        check("tbl flags",      {30'd0, overrun, frame_err}, 32'd0);

        // ---- Overrun: two more frames complete while not ready.
        set_ready(1'b0);
        a = n_acc;
        send_frame(16'h1234, 16'h1111, 16, 4'h0);
        send_frame(16'h5678, 16'h2222, 16, 4'h0);
        send_frame(16'h0000, 16'h0000, 16, 4'h0);
        check("ovr left",    {16'd0, out_left},  32'h5678);
        check("ovr right",   {16'd0, out_right}, 32'h2222);
        check("ovr valid",   {31'd0, out_valid}, 32'd1);
        check("ovr flag",    {31'd0, overrun},   32'd1);
        check("ovr no xfer", n_acc - a, 0);
        pulse_clr();
        @(negedge clk);
        check("ovr cleared", {31'd0, overrun},   32'd0);
        check("ovr stable",  {16'd0, out_left},  32'h5678);
        set_ready(1'b1);
        @(posedge clk); #1;
        check("ovr accept drop", {31'd0, out_valid}, 32'd0);
        check("ovr accept data", {16'd0, last_l},    32'h5678);
        check("ovr accept cnt",  n_acc - a, 1);

        // ---- Short left word of 10 bits: that frame is dropped.
        a = n_acc;
        send_word(1'b1, 16'hFFC0, 10, 4'h0);
        send_word(1'b0, 16'hBEEF, 16, 4'h0);
        send_frame(16'h0F0F, 16'hF0F0, 16, 4'h0);
        send_frame(16'h0000, 16'h0000, 16, 4'h0);
        check("short ferr",  {31'd0, frame_err}, 32'd1);
        check("short count", n_acc - a, 2);
        check("short left",  {16'd0, last_l}, 32'h0F0F);
        check("short right", {16'd0, last_r}, 32'hF0F0);
        pulse_clr();
        @(negedge clk);
        check("short cleared", {31'd0, frame_err}, 32'd0);

        // ---- Reset after 8 right-channel bits.
        send_word(1'b1, 16'hAAAA, 16, 4'h0);
        send_word(1'b0, 16'h5555, 8, 4'h0);
        @(posedge clk); #2 Reset = 1'b1;
        @(posedge clk); #2 Reset = 1'b0;
        @(negedge clk);
        check("rst left",  {16'd0, out_left},  32'd0);
        check("rst right", {16'd0, out_right}, 32'd0);
        check("rst valid", {31'd0, out_valid}, 32'd0);
        check("rst level", {28'd0, level},     32'd0);
        check("rst state", {30'd0, dut.r_state}, 32'd0);
        a2 = n_acc;
        send_word(1'b0, 16'h5500, 8, 4'h0);
        send_frame(16'h1357, 16'h2468, 16, 4'h0);
        check("rst no frame", n_acc - a2, 0);
        send_frame(16'h0000, 16'h0000, 16, 4'h0);
        check("rst count", n_acc - a2, 1);
        check("rst left2", {16'd0, last_l}, 32'h1357);
        check("rst right2", {16'd0, last_r}, 32'h2468);
        check("rst level2", {28'd0, level}, 32'h2);
        check("rst flags", {30'd0, overrun, frame_err}, 32'd0);

        // ---- 20-bit slots: trailing bits ignored.
        a = n_acc;
        send_frame(16'hA5A5, 16'h5A5A, 20, 4'hB);
        send_frame(16'h0000, 16'h0000, 16, 4'h0);
        check("wide count", n_acc - a, 2);
        check("wide left",  {16'd0, last_l}, 32'hA5A5);
        check("wide right", {16'd0, last_r}, 32'h5A5A);
        check("wide level", {28'd0, level},  32'hB);
        check("wide ferr",  {31'd0, frame_err}, 32'd0);

        // ---- enable low for three frames.
        enable = 1'b0;
        a  = n_acc;
        vr = n_vrise;
        send_frame(16'h1111, 16'h1010, 16, 4'h0);
        send_frame(16'h2222, 16'h2020, 16, 4'h0);
        send_frame(16'h3333, 16'h3030, 16, 4'h0);
        check("en off vrise", n_vrise - vr, 0);
        check("en off valid", {31'd0, out_valid}, 32'd0);
        enable = 1'b1;
        send_frame(16'h4444, 16'h4040, 16, 4'h0);
        check("en first cnt",  n_acc - a, 1);
        check("en first left", {16'd0, last_l}, 32'h3333);
        check("en first right", {16'd0, last_r}, 32'h3030);
        send_frame(16'h0000, 16'h0000, 16, 4'h0);
        check("en second cnt",  n_acc - a, 2);
        check("en second left", {16'd0, last_l}, 32'h4444);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_audio_adc_receiver
`default_nettype wire
